// File: rtl/lsu_mem_port_pkg.sv
// lsu_mem_pkg: shared constants and helpers for the LSU memory port.
//   - request size encodings
//   - FSM state encodings (2-bit constants)
//   - lane_mask   : size + beat offset -> 8-bit byte-lane enables
//   - expand_mask : byte-lane enables -> 64-bit per-bit write mask
//   - store_beat  : LSB-justified store data replicated across the beat
//   - misaligned  : access error check (reserved size or unaligned)
`timescale 1ns/1ps

package lsu_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam logic [1:0] SIZE_RSVD = 2'd3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    function automatic logic [7:0] lane_mask(input logic [1:0] size,
                                             input logic [2:0] offset);
        logic [7:0] base;
        case (size)
            SIZE_BYTE: base = 8'h01;
            SIZE_HALF: base = 8'h03;
            SIZE_WORD: base = 8'h0F;
            default:   base = 8'h00;
        endcase
        return base << offset;
    endfunction

    function automatic logic [63:0] expand_mask(input logic [7:0] be);
        logic [63:0] m;
        m = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

    // The memory picks the lanes via wmask, so the data is simply
    // replicated and every lane carries the correct bytes.
    function automatic logic [63:0] store_beat(input logic [1:0]  size,
                                               input logic [31:0] data);
        case (size)
            SIZE_BYTE: return {8{data[7:0]}};
            SIZE_HALF: return {4{data[15:0]}};
            default:   return {2{data}};
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size,
                                        input logic [1:0] lo);
        return (size == SIZE_RSVD)
            || (size == SIZE_HALF && lo[0])
            || (size == SIZE_WORD && lo != 2'b00);
    endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Interfaces for the LSU memory port.
//   lsu_req_if : LSU request/response handshake
//       master = LSU (drives req_*), slave = lsu_mem_port
//       req_valid/req_ready, req_we, req_size, req_unsigned, req_addr,
//       req_wdata, rsp_valid, rsp_rdata, rsp_err
//   mem_bus_if : simulation memory pins
//       master = lsu_mem_port, slave = memory
//       ncs, nwe (active-low), addr, wdata, wmask, rdata
`timescale 1ns/1ps

interface lsu_req_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

interface mem_bus_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    logic                  ncs;
    logic                  nwe;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] wmask;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output ncs, nwe, addr, wdata, wmask,
        input  rdata
    );

    modport slave (
        input  ncs, nwe, addr, wdata, wmask,
        output rdata
    );
endinterface

// File: rtl/lsu_mem_port_load_align.sv
// lsu_load_align: picks the addressed byte/half/word out of a 64-bit read
// beat and sign- or zero-extends it to 32 bits. Purely combinational.
//   beat        in  64  read beat
//   offset      in  3   byte offset of the access inside the beat
//   size        in  2   0 byte, 1 half, 2 word
//   is_unsigned in  1   zero-extend when 1
//   result      out 32  extended load data
`timescale 1ns/1ps

module lsu_load_align
    import lsu_mem_pkg::*;
(
    input  logic [63:0] beat,
    input  logic [2:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [31:0] lane;

    // Accesses are naturally aligned, so shifting by the byte offset lands
    // the addressed halfword/word at bit 0 as well.
    always_comb begin
        lane = 32'(beat >> {offset, 3'b000});
    end

    always_comb begin
        result = '0;
        case (size)
            SIZE_BYTE: result = is_unsigned ? {24'h0, lane[7:0]}
                                            : {{24{lane[7]}}, lane[7:0]};
            SIZE_HALF: result = is_unsigned ? {16'h0, lane[15:0]}
                                            : {{16{lane[15]}}, lane[15:0]};
            default:   result = lane;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: initiator side of the 64-bit simulation memory port.
// Takes one load/store at a time from the LSU, rejects misaligned or
// reserved-size requests without a memory cycle, drives the active-low
// memory strobes for exactly one cycle, and returns one response strobe.
//   clk, nrst : clock, asynchronous active-low reset
//   lsu       : request/response handshake (lsu_req_if.slave)
//   mem       : memory pins (mem_bus_if.master)
// Store: IDLE -> ACCESS -> RESP. Load: IDLE -> ACCESS -> WAIT -> RESP.
// Error: IDLE -> RESP.
`timescale 1ns/1ps

module lsu_mem_port
    import lsu_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
) (
    input  logic       clk,
    input  logic       nrst,
    lsu_req_if.slave   lsu,
    mem_bus_if.master  mem
);

    logic [1:0]            state;
    logic                  we_q;
    logic [1:0]            size_q;
    logic [2:0]            off_q;
    logic                  uns_q;
    logic                  ncs_q;
    logic                  nwe_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] wmask_q;
    logic [31:0]           rdata_q;
    logic                  err_q;

    logic                  req_bad;
    logic [31:0]           ld_result;

    assign req_bad = misaligned(lsu.req_size, lsu.req_addr[1:0]);

    lsu_load_align u_align (
        .beat        (mem.rdata),
        .offset      (off_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .result      (ld_result)
    );

    // Memory strobes are registered at accept so they are valid for the
    // whole ACCESS cycle; the memory acts on the edge that leaves ACCESS.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= ST_IDLE;
            we_q    <= 1'b0;
            size_q  <= SIZE_BYTE;
            off_q   <= '0;
            uns_q   <= 1'b0;
            ncs_q   <= 1'b1;
            nwe_q   <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (lsu.req_valid) begin
                        we_q   <= lsu.req_we;
                        size_q <= lsu.req_size;
                        off_q  <= lsu.req_addr[2:0];
                        uns_q  <= lsu.req_unsigned;
                        if (req_bad) begin
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                            state   <= ST_RESP;
                        end else begin
                            ncs_q  <= 1'b0;
                            nwe_q  <= ~lsu.req_we;
                            addr_q <= {lsu.req_addr[ADDR_WIDTH-1:3], 3'b000};
                            if (lsu.req_we) begin
                                wdata_q <= store_beat(lsu.req_size, lsu.req_wdata);
                                wmask_q <= expand_mask(lane_mask(lsu.req_size,
                                                                 lsu.req_addr[2:0]));
                            end
                            state <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    ncs_q   <= 1'b1;
                    nwe_q   <= 1'b1;
                    wmask_q <= '0;
                    if (we_q) begin
                        err_q   <= 1'b0;
                        rdata_q <= '0;
                        state   <= ST_RESP;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    err_q   <= 1'b0;
                    rdata_q <= ld_result;
                    state   <= ST_RESP;
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign lsu.req_ready = (state == ST_IDLE);
    assign lsu.rsp_valid = (state == ST_RESP);
    assign lsu.rsp_rdata = rdata_q;
    assign lsu.rsp_err   = err_q;

    assign mem.ncs   = ncs_q;
    assign mem.nwe   = nwe_q;
    assign mem.addr  = addr_q;
    assign mem.wdata = wdata_q;
    assign mem.wmask = wmask_q;

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Initiator side of the 64-bit simulation memory port. Accepts single load/store requests from the RV32IMA load/store unit (byte/half/word, signed/unsigned), checks alignment, and drives the memory chip-select/write-enable/address/data/mask interface. For loads it captures the 64-bit read beat, extracts the addressed lane and sign- or zero-extends it. Returns one response per request, including a misalignment error, to the LSU.

## Interface
- ADDR_WIDTH, 32, byte address width on both sides
- DATA_WIDTH, 64, memory beat width; fixed at 64 (8 byte lanes)
- clk  in  1  clock; all state on posedge
- nrst  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  block can accept (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 byte, 1 half, 2 word, 3 reserved
- req_unsigned  in  1  load zero-extends when 1
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  32  store data, LSB-justified
- rsp_valid  out  1  one-cycle response strobe; no backpressure
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned or reserved-size request; qualified by rsp_valid
- ncs  out  1  memory chip select, active-low
- nwe  out  1  memory write enable, active-low
- addr  out  ADDR_WIDTH  beat address, addr[2:0] always 0
- wdata  out  DATA_WIDTH  write beat
- wmask  out  DATA_WIDTH  per-bit write mask, 8'hFF per enabled lane
- rdata  in  DATA_WIDTH  read beat, valid the cycle after a read edge

## Operation
- FSM states IDLE, ACCESS, WAIT, RESP. Accept on valid&ready in IDLE; request fields latched.
- Error check at accept: size 3, half with addr[0]=1, or word with addr[1:0]!=0 -> IDLE->RESP, rsp_err=1, rsp_rdata=0, no memory cycle.
- Store: IDLE->ACCESS (ncs=0, nwe=0)->RESP->IDLE. wdata replicates data across lanes (byte to all 8, half to all 4, word to both halves); wmask enables lanes base+addr[2:0] .. +size bytes only. Lane i = bits [8i+7:8i] = byte address addr_beat+i.
- Load: IDLE->ACCESS (ncs=0, nwe=1)->WAIT->RESP->IDLE. In WAIT rdata is sampled; byte lane = addr[2:0], half = addr[2:1], word = addr[2]; sign-extend unless req_unsigned; result registered into rsp_rdata at WAIT->RESP edge.
- rdata is ignored outside WAIT (memory drives X when not selected).
- Outside ACCESS: ncs=1, nwe=1, wmask=0; addr/wdata hold last value.

## Timing
- Reset values: ncs=1, nwe=1, addr=0, wdata=0, wmask=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, state IDLE (req_ready=1).
- Accept edge E0. Store: memory write at E1, rsp_valid high cycle after E1 (3 cycles/request incl. RESP). Load: read at E1, rdata valid cycle after E1, rsp_valid high cycle after E2 (4 cycles/request). Error: rsp_valid high cycle after E0.
- rsp_valid high exactly one cycle; next request accepted no earlier than the edge after RESP.
- nrst assertion mid-operation: outputs return to reset values immediately; ncs deasserts asynchronously. Store aborted before E1 does not write; no response is produced for an aborted request.
- req_* ignored while req_ready=0.

## Structure
- Package lsu_mem_pkg: size encoding constants, state enum, function lane_mask(size, offset) returning 8-bit byte enables, function expand_mask (8 -> 64 bit).
- Sub-module lsu_load_align: combinational 64-bit beat + offset + size + unsigned -> 32-bit result.

## Test plan
- Store word 0xDEADBEEF @0x1004 -> ACCESS: addr=0x1000, nwe=0, wmask=0xFFFFFFFF_00000000, wdata upper=0xDEADBEEF; rsp_valid 2 cycles after accept, rsp_err=0.
- Load byte signed @0x1007 with beat 0x80xx_xxxx_xxxx_xxxx -> rsp_rdata=0xFFFFFF80; same with req_unsigned=1 -> 0x00000080; rsp_valid 3 cycles after accept.
- Store half 0x1234 @0x2002 then load half unsigned @0x2002 against reference memory -> 0x00001234; wmask=0x00000000_FFFF0000.
- Misaligned word @0x3001 and size=3 -> rsp_err=1 next cycle, rsp_rdata=0, ncs never low.
- nrst pulse while in ACCESS of a store -> ncs=1 immediately, no write, no rsp_valid, req_ready=1 after release.
- 100 back-to-back random aligned loads/stores vs scoreboard -> all data match, req_ready low outside IDLE.
